transposer_job_sched: RTL and testbench
=======================================

// Module: transposer_job_sched
// PURPOSE
//  Round-robin job scheduler in front of one transposer instance. Accepts transpose job
//  descriptors from NREQ requesters via valid/ready and latches the granted one.
//  Drives it onto the transposer config ports and fires a one-cycle init pulse.
//  Waits for the transposer finish (with watchdog) and returns a done/err pulse to the owner.
// PARAMETERS
//  NREQ     2     number of requesters (>=2)
//  AW       16    address/count width; must match transposer AW
//  ADIM     6     address-generator nesting depth; must match transposer ADIM
//  TMO_CYC  65535 watchdog limit in cycles while a job runs; 0 = watchdog disabled
// PORTS
//  clk          in   1                 clock
//  reset_n      in   1                 asynchronous active-low reset
//  req_vld      in   NREQ              requester i has a descriptor
//  req_rdy      out  NREQ              descriptor i accepted this cycle (when req_vld[i])
//  req_desc     in   NREQ x trp_desc_t job descriptor per requester
//  cfg_desc     out  trp_desc_t        registered config to transposer (mode, repack_en, addr/size/stride, dims)
//  trp_init     out  1                 one-cycle init pulse to transposer
//  trp_finish   in   1                 transposer finish pulse
//  done         out  NREQ              one-cycle completion pulse to owning requester
//  done_err     out  1                 qualifies done: 1 = watchdog expired
//  busy         out  1                 high from accept until done cycle inclusive
//  cur_owner    out  $clog2(NREQ)      index of requester owning current/last job
// BEHAVIOUR
//  Reset: state IDLE; req_rdy=0, cfg_desc=0, trp_init=0, done=0, done_err=0, busy=0,
//   cur_owner=0, rr pointer=0, watchdog=0. Reset mid-job discards the job silently; no done.
//  FSM IDLE->START->RUN->DONE->IDLE.
//  IDLE: grant g = first i with req_vld[i], scanning from rr_ptr upward modulo NREQ.
//   req_rdy[g]=1 combinationally, other bits 0; if no req_vld, stay. On accept (cycle T):
//   cfg_desc<=req_desc[g], cur_owner<=g, rr_ptr<=(g+1)%NREQ, busy<=1, ->START.
//  START (T+1): trp_init=1 for exactly this cycle; cfg_desc already stable; ->RUN.
//  RUN: watchdog counts from 0 each cycle. trp_finish=1 -> DONE with err=0.
//   If TMO_CYC!=0 and count==TMO_CYC-1 with no finish -> DONE with err=1.
//   finish and timeout in same cycle: finish wins (err=0).
//  DONE: done[cur_owner]=1, done_err=err for one cycle; busy=1 this cycle, 0 next; ->IDLE.
//   Next accept earliest the cycle after DONE; min job-to-job gap = finish + 2 cycles.
//  cfg_desc held constant from START through the IDLE cycles that follow, until next accept;
//   transposer reloads dim counters mid-job, so config must not change while RUN.
//  trp_finish outside RUN is ignored (no done, no state change).
//  req_rdy is 0 in START/RUN/DONE; requesters must hold req_vld/req_desc until req_rdy.
//  Watchdog width $clog2(TMO_CYC+1), saturates; cleared on entry to RUN.
//  done_err low whenever done is low.
// STRUCTURE
//  Package trp_pkg: trp_mode_e (BIT8_MODE=2'b01, BIT32_MODE=2'b10); trp_desc_t packed struct
//   {mode, repack_en, rreq_num, raddr_base, raddr_size[ADIM], raddr_stride[ADIM], wreq_num,
//   waddr_base, waddr_size[ADIM], waddr_stride[ADIM], packed_dim_size, unpacked_dim_size};
//   sched_state_e {IDLE, START, RUN, DONE}. Package ADIM/AW defaults match transposer.
//  One sub-module: rr_arbiter (NREQ req, rr_ptr in -> one-hot grant + index), combinational.
//  Top: FSM, descriptor register, watchdog, done/owner logic; unpacks cfg_desc to transposer.
// TESTING
//  Single job: req_vld[0] with desc, finish 40 cycles after init -> rdy[0] 1 cycle,
//   trp_init at accept+1, done[0]=1 done_err=0 at finish+1, busy low at finish+2.
//  Contention: req_vld=2'b11 held, 4 jobs -> owners 0,1,0,1; no overlapping trp_init;
//   cfg_desc matches owner's desc throughout each RUN.
//  Watchdog: TMO_CYC=16, no finish -> done[owner]=1, done_err=1 exactly 16 cycles after
//   RUN entry; next queued job then starts normally.
//  Finish/timeout tie: TMO_CYC=16, finish on 16th RUN cycle -> done_err=0.
//  Stray finish: pulse trp_finish while IDLE and START -> no done, state unchanged.
//  Reset mid-RUN: drop reset_n for 3 cycles -> all outputs 0, rr_ptr=0, no done; fresh job
//   after reset completes normally.

Source files
------------

// File: rtl/trp_pkg.sv
// Shared types for the transposer job scheduler: job descriptor layout,
// transposer mode encoding, scheduler FSM states and the round-robin wrap helper.
package trp_pkg;

    // Geometry of the transposer this scheduler feeds; the descriptor layout depends on it
    localparam int TRP_AW   = 16;
    localparam int TRP_ADIM = 6;

    typedef enum logic [1:0] {
        BIT8_MODE  = 2'b01,
        BIT32_MODE = 2'b10
    } trp_mode_e;

    typedef struct packed {
        trp_mode_e                          mode;
        logic                               repack_en;
        logic [TRP_AW-1:0]                  rreq_num;
        logic [TRP_AW-1:0]                  raddr_base;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]    raddr_size;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]    raddr_stride;
        logic [TRP_AW-1:0]                  wreq_num;
        logic [TRP_AW-1:0]                  waddr_base;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]    waddr_size;
        logic [TRP_ADIM-1:0][TRP_AW-1:0]    waddr_stride;
        logic [TRP_AW-1:0]                  packed_dim_size;
        logic [TRP_AW-1:0]                  unpacked_dim_size;
    } trp_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } sched_state_e;

    // Candidate index k positions after the pointer, wrapped into [0, n)
    function automatic int rrWrap(input int ptr, input int k, input int n);
        return (ptr + k) % n;
    endfunction

endpackage

// File: rtl/transposer_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the priority pointer (wrapping), returning a one-hot grant and its index.
module rr_arbiter
    import trp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int        cand;
    logic [IW-1:0] candIdx;
    logic      found;

    // Scan from the pointer upward and take the first requester that is valid
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        candIdx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand    = rrWrap(int'(ptr_i), k, NREQ);
            candIdx = IW'(cand);
            if (!found && req_i[candIdx]) begin
                found            = 1'b1;
                grant_o[candIdx] = 1'b1;
                idx_o            = candIdx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/transposer_job_sched.sv
// Round-robin job scheduler in front of a single transposer: accepts one
// descriptor at a time, holds it on the config port, fires init, waits for
// finish under a watchdog, and returns a done/err pulse to the owning requester.
module transposer_job_sched
    import trp_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 16,
    parameter int ADIM    = 6,
    parameter int TMO_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_vld,
    output logic [NREQ-1:0]         req_rdy,
    input  trp_desc_t               req_desc [NREQ],
    output trp_desc_t               cfg_desc,
    output logic                    trp_init,
    input  logic                    trp_finish,
    output logic [NREQ-1:0]         done,
    output logic                    done_err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] cur_owner
);

    localparam int IW  = $clog2(NREQ);
    localparam int WDW = (TMO_CYC == 0) ? 1 : $clog2(TMO_CYC + 1);
    localparam bit WDOG_EN = (TMO_CYC != 0);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TMO_CYC - 1);
    localparam logic [WDW-1:0] WDOG_MAX  = '1;

    // The descriptor layout is fixed by the package, so the geometry must agree with it
    if (AW != TRP_AW || ADIM != TRP_ADIM || NREQ < 2) begin : g_bad_params
        $error("transposer_job_sched: NREQ must be >=2 and AW/ADIM must match trp_pkg");
    end

    sched_state_e    state_q, state_d;
    trp_desc_t       cfgDesc_q;
    logic [IW-1:0]   curOwner_q;
    logic [IW-1:0]   rrPtr_q;
    logic            busy_q;
    logic [WDW-1:0]  wdog_q;
    logic            err_q;
    logic            err_d;
    logic            accept;
    logic            wdogHit;
    logic [NREQ-1:0] grantVec;
    logic [IW-1:0]   grantIdx;
    logic            grantAny;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (req_vld),
        .ptr_i   (rrPtr_q),
        .grant_o (grantVec),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    assign wdogHit   = WDOG_EN && (wdog_q == WDOG_LAST);
    assign cfg_desc  = cfgDesc_q;
    assign busy      = busy_q;
    assign cur_owner = curOwner_q;

    // Next-state and handshake/pulse outputs decoded from the current state
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        accept   = 1'b0;
        req_rdy  = '0;
        trp_init = 1'b0;
        done     = '0;
        done_err = 1'b0;
        case (state_q)
            IDLE: begin
                req_rdy = grantVec;
                if (grantAny) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                trp_init = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (trp_finish) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (wdogHit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done     = NREQ'(1) << curOwner_q;
                done_err = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; a reset mid-job drops the job without any completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Descriptor latch, ownership, round-robin pointer, busy flag, watchdog and error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfgDesc_q  <= '0;
            curOwner_q <= '0;
            rrPtr_q    <= '0;
            busy_q     <= 1'b0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                cfgDesc_q  <= req_desc[grantIdx];
                curOwner_q <= grantIdx;
                rrPtr_q    <= (grantIdx == IW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
                busy_q     <= 1'b1;
            end
            if (state_q == DONE) begin
                busy_q <= 1'b0;
            end
            if (state_q == START) begin
                wdog_q <= '0;
            end else if (state_q == RUN && wdog_q != WDOG_MAX) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (state_q == RUN) begin
                err_q <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_transposer_job_sched.sv
// Directed bench for transposer_job_sched: one instance with the default
// watchdog for the scheduling/stray/reset scenarios, one with a 16-cycle watchdog.
module tb_transposer_job_sched;
    import trp_pkg::*;

    logic      clk;
    logic      reset_n;

    logic [1:0] vldA, rdyA, doneA;
    trp_desc_t  descA [2];
    trp_desc_t  cfgA;
    logic       initA, finA, errA, busyA;
    logic [0:0] ownerA;

    logic [1:0] vldB, rdyB, doneB;
    trp_desc_t  descB [2];
    trp_desc_t  cfgB;
    logic       initB, finB, errB, busyB;
    logic [0:0] ownerB;

    int testCount = 0;
    int failCount = 0;

    transposer_job_sched #(.NREQ(2), .AW(16), .ADIM(6), .TMO_CYC(65535)) dutA (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_vld    (vldA),
        .req_rdy    (rdyA),
        .req_desc   (descA),
        .cfg_desc   (cfgA),
        .trp_init   (initA),
        .trp_finish (finA),
        .done       (doneA),
        .done_err   (errA),
        .busy       (busyA),
        .cur_owner  (ownerA)
    );

    transposer_job_sched #(.NREQ(2), .AW(16), .ADIM(6), .TMO_CYC(16)) dutB (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_vld    (vldB),
        .req_rdy    (rdyB),
        .req_desc   (descB),
        .cfg_desc   (cfgB),
        .trp_init   (initB),
        .trp_finish (finB),
        .done       (doneB),
        .done_err   (errB),
        .busy       (busyB),
        .cur_owner  (ownerB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic trp_desc_t mkDesc(input int seed);
        trp_desc_t d;
        d = '0;
        d.mode              = seed[0] ? BIT32_MODE : BIT8_MODE;
        d.repack_en         = seed[1];
        d.rreq_num          = 16'(seed * 3 + 1);
        d.raddr_base        = 16'(seed * 16'h0100);
        d.wreq_num          = 16'(seed * 5 + 2);
        d.waddr_base        = 16'(16'h8000 + seed * 16'h0040);
        d.packed_dim_size   = 16'(seed + 4);
        d.unpacked_dim_size = 16'(seed + 8);
        for (int i = 0; i < TRP_ADIM; i++) begin
            d.raddr_size[i]   = 16'(seed * 16 + i);
            d.raddr_stride[i] = 16'(seed * 32 + i * 2);
            d.waddr_size[i]   = 16'(seed * 64 + i * 3);
            d.waddr_stride[i] = 16'(seed * 128 + i * 4);
        end
        return d;
    endfunction

    // Advance to just after the next falling edge, away from the active edge
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkDesc(input string tag, input trp_desc_t obs, input trp_desc_t exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One job on dutA starting in its accept cycle; finish arrives runLen cycles after init
    task automatic jobA(input int owner, input int runLen, input bit dropVld);
        trp_desc_t exp;
        exp = descA[owner];
        checkOutput("A_rdy_accept", 32'(rdyA), 32'(1 << owner));
        checkOutput("A_busy_accept", 32'(busyA), 32'd0);
        cyc();
        if (dropVld) vldA = 2'b00;
        #1;
        checkOutput("A_init_start", 32'(initA), 32'd1);
        checkOutput("A_busy_start", 32'(busyA), 32'd1);
        checkOutput("A_owner_start", 32'(ownerA), 32'(owner));
        checkOutput("A_rdy_start", 32'(rdyA), 32'd0);
        checkDesc("A_cfg_start", cfgA, exp);
        for (int k = 1; k < runLen; k++) begin
            cyc();
            checkOutput("A_init_run", 32'(initA), 32'd0);
            checkOutput("A_rdy_run", 32'(rdyA), 32'd0);
            checkOutput("A_done_run", 32'(doneA), 32'd0);
            checkDesc("A_cfg_run", cfgA, exp);
        end
        cyc();
        finA = 1'b1;
        checkOutput("A_done_fin", 32'(doneA), 32'd0);
        checkDesc("A_cfg_fin", cfgA, exp);
        cyc();
        finA = 1'b0;
        checkOutput("A_done", 32'(doneA), 32'(1 << owner));
        checkOutput("A_done_err", 32'(errA), 32'd0);
        checkOutput("A_busy_done", 32'(busyA), 32'd1);
        cyc();
        checkOutput("A_busy_after", 32'(busyA), 32'd0);
        checkOutput("A_done_after", 32'(doneA), 32'd0);
        checkDesc("A_cfg_idle_hold", cfgA, exp);
    endtask

    // One job on dutB (16-cycle watchdog); finAt is the RUN cycle index carrying finish, -1 for none
    task automatic jobB(input int owner, input int finAt, input bit expErr, input bit dropAtDone);
        checkOutput("B_rdy_accept", 32'(rdyB), 32'(1 << owner));
        cyc();
        checkOutput("B_init_start", 32'(initB), 32'd1);
        checkOutput("B_owner_start", 32'(ownerB), 32'(owner));
        for (int idx = 0; idx < 16; idx++) begin
            cyc();
            finB = (idx == finAt);
            checkOutput("B_done_run", 32'(doneB), 32'd0);
            checkOutput("B_err_run", 32'(errB), 32'd0);
            checkDesc("B_cfg_run", cfgB, descB[owner]);
        end
        cyc();
        finB = 1'b0;
        if (dropAtDone) vldB = 2'b00;
        checkOutput("B_done", 32'(doneB), 32'(1 << owner));
        checkOutput("B_done_err", 32'(errB), 32'(expErr));
        checkOutput("B_busy_done", 32'(busyB), 32'd1);
        cyc();
        checkOutput("B_done_after", 32'(doneB), 32'd0);
        checkOutput("B_err_after", 32'(errB), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        vldA = 2'b00; finA = 1'b0;
        vldB = 2'b00; finB = 1'b0;
        descA[0] = mkDesc(1); descA[1] = mkDesc(2);
        descB[0] = mkDesc(7); descB[1] = mkDesc(8);

        // Reset state
        cyc();
        checkOutput("rst_rdyA", 32'(rdyA), 32'd0);
        checkDesc("rst_cfgA", cfgA, '0);
        checkOutput("rst_initA", 32'(initA), 32'd0);
        checkOutput("rst_doneA", 32'(doneA), 32'd0);
        checkOutput("rst_errA", 32'(errA), 32'd0);
        checkOutput("rst_busyA", 32'(busyA), 32'd0);
        checkOutput("rst_ownerA", 32'(ownerA), 32'd0);
        checkOutput("rst_busyB", 32'(busyB), 32'd0);
        checkDesc("rst_cfgB", cfgB, '0);
        reset_n = 1'b1;
        cyc();

        // Contention: both requesters held, owners alternate 0,1,0,1 back to back
        vldA = 2'b11;
        #1;
        for (int j = 0; j < 4; j++) begin
            jobA(j % 2, 5, (j == 3));
        end
        cyc();
        checkOutput("A_rdy_quiet", 32'(rdyA), 32'd0);
        checkOutput("A_busy_quiet", 32'(busyA), 32'd0);

        // Single job from requester 0, finish 40 cycles after init
        descA[0] = mkDesc(3);
        vldA = 2'b01;
        #1;
        jobA(0, 40, 1'b1);

        // Stray finish while IDLE is ignored
        cyc();
        finA = 1'b1;
        checkOutput("stray_idle_done", 32'(doneA), 32'd0);
        checkOutput("stray_idle_busy", 32'(busyA), 32'd0);
        cyc();
        finA = 1'b0;
        checkOutput("stray_idle_done2", 32'(doneA), 32'd0);
        checkOutput("stray_idle_busy2", 32'(busyA), 32'd0);
        checkOutput("stray_idle_init", 32'(initA), 32'd0);

        // Stray finish during START is ignored; job then runs to a normal finish
        descA[1] = mkDesc(4);
        vldA = 2'b10;
        #1;
        checkOutput("stray_rdy", 32'(rdyA), 32'b10);
        cyc();
        vldA = 2'b00;
        finA = 1'b1;
        checkOutput("stray_start_init", 32'(initA), 32'd1);
        cyc();
        finA = 1'b0;
        checkOutput("stray_run_init", 32'(initA), 32'd0);
        checkOutput("stray_run_done", 32'(doneA), 32'd0);
        checkOutput("stray_run_busy", 32'(busyA), 32'd1);
        cyc();
        checkOutput("stray_run_done2", 32'(doneA), 32'd0);
        checkOutput("stray_run_busy2", 32'(busyA), 32'd1);
        finA = 1'b1;
        cyc();
        finA = 1'b0;
        checkOutput("stray_done", 32'(doneA), 32'b10);
        checkOutput("stray_done_err", 32'(errA), 32'd0);
        cyc();
        checkOutput("stray_busy_after", 32'(busyA), 32'd0);

        // Watchdog: owner 0 never finishes, owner 1 finishes on the 16th RUN cycle
        vldB = 2'b11;
        #1;
        jobB(0, -1, 1'b1, 1'b0);
        jobB(1, 15, 1'b0, 1'b1);
        checkOutput("B_rdy_quiet", 32'(rdyB), 32'd0);
        checkOutput("B_busy_quiet", 32'(busyB), 32'd0);

        // Reset in the middle of RUN discards the job and the round-robin pointer
        descA[0] = mkDesc(5);
        descA[1] = mkDesc(6);
        vldA = 2'b01;
        #1;
        checkOutput("rstrun_rdy", 32'(rdyA), 32'b01);
        cyc();
        vldA = 2'b00;
        cyc();
        cyc();
        checkOutput("rstrun_busy_pre", 32'(busyA), 32'd1);
        reset_n = 1'b0;
        for (int r = 0; r < 3; r++) begin
            #1;
            checkOutput("rstrun_done", 32'(doneA), 32'd0);
            checkOutput("rstrun_busy", 32'(busyA), 32'd0);
            checkOutput("rstrun_init", 32'(initA), 32'd0);
            checkOutput("rstrun_owner", 32'(ownerA), 32'd0);
            checkOutput("rstrun_err", 32'(errA), 32'd0);
            checkDesc("rstrun_cfg", cfgA, '0);
            cyc();
        end
        reset_n = 1'b1;
        checkOutput("rstrun_done_rel", 32'(doneA), 32'd0);
        vldA = 2'b11;
        #1;
        jobA(0, 8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
